// File: rtl/imem_line_server.sv
// imem_line_server: instruction-memory line responder for cache line fills.
// Accepts one request at a time, waits LATENCY cycles, returns a 4-word line
// on a one-cycle valid pulse. The program store is preloaded via load_*.
module imem_line_server #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [31:0]  req_addr,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [127:0] resp_line,
  output logic [31:0]  resp_addr,
  input  logic         load_en,
  input  logic [31:0]  load_addr,
  input  logic [31:0]  load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  load_idx;
  logic [AW-1:0]  idx0;
  logic [AW-1:0]  idx1;
  logic [AW-1:0]  idx2;
  logic [AW-1:0]  idx3;

  // Store indices wrap modulo DEPTH_WORDS; the latched base is line-aligned,
  // so the three following words never cross a line boundary.
  assign load_idx = AW'(load_addr % DEPTH_WORDS);
  assign idx0     = AW'(resp_addr % DEPTH_WORDS);
  assign idx1     = idx0 + AW'(1);
  assign idx2     = idx0 + AW'(2);
  assign idx3     = idx0 + AW'(3);

  // Program store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  // Request FSM with registered handshake outputs; the line sample reads the
  // store before any same-edge write lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_line  <= '0;
      resp_addr  <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_addr <= req_addr & ~32'd3;
            count     <= CW'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (count == '0) begin
            resp_line  <= {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            count <= count - CW'(1);
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_line_server.sv
// Testbench for imem_line_server: directed scenarios plus random traffic,
// checked by a cycle-level reference model feeding a response scoreboard.
module tb_imem_line_server;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         load_en = 1'b0;
  logic [31:0]  load_addr = '0;
  logic [31:0]  load_data = '0;
  logic         req_ready;
  logic         resp_valid;
  logic [127:0] resp_line;
  logic [31:0]  resp_addr;

  imem_line_server #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_line (resp_line),
    .resp_addr (resp_addr),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int unsigned  due;
    logic [31:0]  addr;
    logic [127:0] line;
  } resp_t;

  resp_t        sb[$];
  int unsigned  rd_ptr = 0;

  logic [31:0]  ref_mem [DEPTH];
  int unsigned  edge_n = 0;
  bit           busy = 1'b0;
  int unsigned  acc_edge = 0;
  logic [31:0]  acc_base = '0;
  logic [127:0] exp_line = '0;
  logic [31:0]  exp_addr = '0;
  bit           prev_reset = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [127:0] ref_line(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      l[127-32*k -: 32] = ref_mem[(base + 32'(k)) % DEPTH];
    end
    return l;
  endfunction

  // Reference model: the line is word base..base+3 as seen just before the
  // sample edge LAT edges after acceptance; the pulse follows that edge and
  // the block is free again one edge later. Reset drops any transfer.
  always @(posedge clk or negedge reset) begin
    if (prev_reset && !reset) begin
      busy     = 1'b0;
      exp_line = '0;
      exp_addr = '0;
      while (sb.size() > rd_ptr && sb[sb.size()-1].due >= edge_n) begin
        void'(sb.pop_back());
      end
    end else begin
      edge_n++;
      if (reset) begin
        if (busy) begin
          if (edge_n == acc_edge + LAT) begin
            exp_line = ref_line(acc_base);
            sb.push_back('{due: edge_n, addr: acc_base, line: exp_line});
          end else if (edge_n == acc_edge + LAT + 1) begin
            busy = 1'b0;
          end
        end else if (req_valid) begin
          busy     = 1'b1;
          acc_edge = edge_n;
          acc_base = req_addr & ~32'd3;
          exp_addr = acc_base;
        end
      end
      if (load_en) begin
        ref_mem[load_addr % DEPTH] = load_data;
      end
    end
    prev_reset = reset;
  end

  // Monitor: compares outputs each falling edge against the model/scoreboard.
  always @(negedge clk) begin
    bit    want;
    resp_t r;
    check("req_ready", {127'd0, req_ready}, {127'd0, !busy});
    want = (sb.size() > rd_ptr) && (sb[rd_ptr].due == edge_n);
    check("resp_valid", {127'd0, resp_valid}, {127'd0, want});
    if (want) begin
      r = sb[rd_ptr];
      rd_ptr++;
      check("resp_line", resp_line, r.line);
      check("resp_addr", {96'd0, resp_addr}, {96'd0, r.addr});
    end
    check("held_line", resp_line, exp_line);
    check("held_addr", {96'd0, resp_addr}, {96'd0, exp_addr});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_timeout", {127'd0, req_ready}, 128'd1);
  endtask

  // Leaves the bench 2ns after the accepting edge E0.
  task automatic request(input logic [31:0] a);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", {127'd0, req_ready}, 128'd1);
    check("rst_valid", {127'd0, resp_valid}, 128'd0);
    check("rst_line", resp_line, 128'd0);
    check("rst_addr", {96'd0, resp_addr}, 128'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", {127'd0, req_ready}, 128'd1);
    check("post_rst_line", resp_line, 128'd0);

    for (int i = 0; i < int'(DEPTH); i++) begin
      do_load(32'(i) | ($urandom() & 32'hFFFF_FC00), $urandom());
    end

    // Basic fill
    for (int i = 0; i < 4; i++) begin
      do_load(32'h40 + 32'(i), 32'hA000_0001 + 32'(i));
    end
    request(32'h42);
    repeat (LAT - 1) tick();
    check("fill_early", {127'd0, resp_valid}, 128'd0);
    tick();
    check("fill_valid", {127'd0, resp_valid}, 128'd1);
    check("fill_line", resp_line, 128'hA0000001_A0000002_A0000003_A0000004);
    check("fill_addr", {96'd0, resp_addr}, 128'h40);
    tick();
    check("fill_pulse_end", {127'd0, resp_valid}, 128'd0);

    // Busy ignore
    request(32'h40);
    tick();
    req_valid = 1'b1;
    req_addr  = 32'h80;
    repeat (3) tick();
    req_valid = 1'b0;
    repeat (LAT) tick();
    check("busy_addr", {96'd0, resp_addr}, 128'h40);
    request(32'h80);
    repeat (LAT + 1) tick();
    check("busy_reissue_addr", {96'd0, resp_addr}, 128'h80);

    // Write before the sample edge is visible
    request(32'h40);
    repeat (LAT - 2) tick();
    do_load(32'h41, 32'hDEAD_BEEF);
    repeat (2) tick();
    check("wr_before", resp_line, 128'hA0000001_DEADBEEF_A0000003_A0000004);

    // Write on the sample edge returns the old word
    do_load(32'h41, 32'hA000_0002);
    request(32'h40);
    repeat (LAT - 1) tick();
    do_load(32'h41, 32'hDEAD_BEEF);
    tick();
    check("wr_on_sample", resp_line, 128'hA0000001_A0000002_A0000003_A0000004);
    do_load(32'h41, 32'hA000_0002);

    // Address wrap
    do_load(32'h0, 32'h1111_1111);
    do_load(32'h1, 32'h2222_2222);
    do_load(32'h2, 32'h3333_3333);
    do_load(32'h3, 32'h4444_4444);
    request(32'h0000_1403);
    repeat (LAT + 1) tick();
    check("wrap_addr", {96'd0, resp_addr}, 128'h1400);
    check("wrap_line", resp_line, 128'h11111111_22222222_33333333_44444444);

    // Reset mid-transfer
    request(32'h40);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("midrst_ready", {127'd0, req_ready}, 128'd1);
    tick();
    reset = 1'b1;
    repeat (LAT + 4) tick();
    check("midrst_line", resp_line, 128'd0);
    check("midrst_addr", {96'd0, resp_addr}, 128'd0);
    request(32'h42);
    repeat (LAT + 1) tick();
    check("midrst_refill", resp_line, 128'hA0000001_A0000002_A0000003_A0000004);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = $urandom();
      load_data = $urandom();
      req_valid = ($urandom_range(0, 4) == 0);
      req_addr  = $urandom();
      reset     = ($urandom_range(0, 99) != 0);
      tick();
    end
    load_en   = 1'b0;
    req_valid = 1'b0;
    reset     = 1'b1;
    repeat (LAT + 3) tick();

    check("sb_drained", 128'(sb.size() - rd_ptr), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
